// File: rtl/vector_mem_responder.sv
// ---------------------------------------------------------------------------
// vector_mem_responder
//   Memory-side responder for the memory stage's byte-serial access bus.
//   The stage issues one byte access per cycle (address, data, write enable)
//   and this block answers with a byte-wide synchronous RAM plus a 16-byte
//   MMIO window (LEDs, push button, access error, ID).
//
//   Read responses are registered, so a read request in cycle N shows up on
//   data_o/rvalid_o in cycle N+1. Reads can be issued every cycle.
//
//   Handshake: a request is accepted in every cycle where req_i is high;
//   there is no back-pressure. Each accepted read produces exactly one
//   rvalid_o pulse one cycle later; writes produce no response.
//
//   Optional feature macro: VECTOR_MEM_ACCESS_COUNTER_EN
//     Adds 16-bit read/write access counters. Their low bytes are readable
//     at MMIO offsets 0x5 (reads) and 0x6 (writes). A write to either offset
//     clears both counters.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   req_i        access strobe; address/data/wren sampled only when high
//   address_i    byte address (A bits)
//   data_i       write data (L bits)
//   wren_i       1 = write, 0 = read
//   button_i     raw asynchronous push-button input
//   data_o       read data, valid the cycle after a read request
//   rvalid_o     one-cycle pulse per completed read
//   LEDs_o       LED register contents
//   range_err_o  sticky out-of-range access flag
// ---------------------------------------------------------------------------
module vector_mem_responder #(
  parameter int            L       = 8,
  parameter int            A       = 32,
  parameter int            DEPTH   = 1024,
  parameter logic [A-1:0]  IO_BASE = 32'hFFFF_FF00,
  parameter int            NLED    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic [A-1:0]    address_i,
  input  logic [L-1:0]    data_i,
  input  logic            wren_i,
  input  logic            button_i,
  output logic [L-1:0]    data_o,
  output logic            rvalid_o,
  output logic [NLED-1:0] LEDs_o,
  output logic            range_err_o
);

  localparam int AW = $clog2(DEPTH);

  // MMIO register offsets within the window
  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_BTN    = 4'h4;
  localparam logic [3:0] OFF_RD_CNT = 4'h5;
  localparam logic [3:0] OFF_WR_CNT = 4'h6;
  localparam logic [3:0] OFF_ERR    = 4'h8;
  localparam logic [3:0] OFF_ID     = 4'hC;
  localparam logic [7:0] ID_VALUE   = 8'hA5;

  // Storage
  logic [L-1:0]    r_mem [DEPTH];
  logic [L-1:0]    r_data;
  logic            r_rvalid;
  logic [NLED-1:0] r_led;
  logic            r_err;
  logic            r_btn_meta;
  logic            r_btn_sync;
  logic            r_btn_prev;
  logic            r_press;

  // Decode
  logic [A-1:0]    w_io_off;
  logic [3:0]      w_off;
  logic            w_is_ram;
  logic            w_is_io;
  logic            w_oor;
  logic            w_rd;
  logic            w_wr;
  logic            w_press_edge;
  logic            w_btn_clr;
  logic            w_err_clr;
  logic [L-1:0]    w_rd_data;

`ifdef VECTOR_MEM_ACCESS_COUNTER_EN
  logic [15:0]     r_rd_cnt;
  logic [15:0]     r_wr_cnt;
  logic            w_cnt_clr;
`endif

  always_comb begin
    w_io_off = address_i - IO_BASE;
    w_off    = w_io_off[3:0];
    w_is_ram = (address_i < A'(DEPTH));
    // Subtracting first keeps the upper bound test free of IO_BASE+16 overflow
    w_is_io  = (address_i >= IO_BASE) && (w_io_off < A'(16));
    w_oor    = !w_is_ram && !w_is_io;
    w_rd     = req_i && !wren_i;
    w_wr     = req_i && wren_i;
    w_press_edge = r_btn_sync && !r_btn_prev;
    w_btn_clr    = w_rd && w_is_io && (w_off == OFF_BTN);
    w_err_clr    = w_wr && w_is_io && (w_off == OFF_ERR);
  end

  // Read data mux; out-of-range and unmapped offsets return 0
  always_comb begin
    w_rd_data = '0;
    if (w_is_ram) begin
      w_rd_data = r_mem[address_i[AW-1:0]];
    end else if (w_is_io) begin
      case (w_off)
        OFF_LED: w_rd_data[NLED-1:0] = r_led;
        OFF_BTN: begin
          w_rd_data[0] = r_btn_sync;
          w_rd_data[1] = r_press;
        end
        OFF_ERR: w_rd_data[0] = r_err;
        OFF_ID:  w_rd_data = L'(ID_VALUE);
`ifdef VECTOR_MEM_ACCESS_COUNTER_EN
        OFF_RD_CNT: w_rd_data = L'(r_rd_cnt[7:0]);
        OFF_WR_CNT: w_rd_data = L'(r_wr_cnt[7:0]);
`endif
        default: w_rd_data = '0;
      endcase
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr && w_is_ram) begin
      r_mem[address_i[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_rvalid   <= 1'b0;
      r_led      <= '0;
      r_err      <= 1'b0;
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_prev <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_data <= w_rd_data;
      end
      if (w_wr && w_is_io && (w_off == OFF_LED)) begin
        r_led <= data_i[NLED-1:0];
      end
      // The clearing write is itself in range, so the two never collide
      if (w_err_clr) begin
        r_err <= 1'b0;
      end else if (req_i && w_oor) begin
        r_err <= 1'b1;
      end
      r_btn_meta <= button_i;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_sync;
      // A new press in the same cycle as the clearing read must not be lost
      if (w_press_edge) begin
        r_press <= 1'b1;
      end else if (w_btn_clr) begin
        r_press <= 1'b0;
      end
    end
  end

`ifdef VECTOR_MEM_ACCESS_COUNTER_EN
  assign w_cnt_clr = w_wr && w_is_io && ((w_off == OFF_RD_CNT) || (w_off == OFF_WR_CNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd && !w_oor) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_wr && !w_oor) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end
`endif

  assign data_o      = r_data;
  assign rvalid_o    = r_rvalid;
  assign LEDs_o      = r_led;
  assign range_err_o = r_err;

endmodule

// File: tb/tb_vector_mem_responder.sv
module tb_vector_mem_responder;

  localparam int          L       = 8;
  localparam int          A       = 32;
  localparam int          DEPTH   = 1024;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;
  localparam int          NLED    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_i;
  logic [A-1:0]    address_i;
  logic [L-1:0]    data_i;
  logic            wren_i;
  logic            button_i;
  logic [L-1:0]    data_o;
  logic            rvalid_o;
  logic [NLED-1:0] LEDs_o;
  logic            range_err_o;

  int n_pass  = 0;
  int n_total = 0;

  vector_mem_responder #(
    .L(L), .A(A), .DEPTH(DEPTH), .IO_BASE(IO_BASE), .NLED(NLED)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .address_i(address_i),
    .data_i(data_i), .wren_i(wren_i), .button_i(button_i),
    .data_o(data_o), .rvalid_o(rvalid_o), .LEDs_o(LEDs_o),
    .range_err_o(range_err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    req_i = 1'b0; wren_i = 1'b0; address_i = '0; data_i = '0;
  endtask

  task automatic set_write(input logic [A-1:0] a, input logic [L-1:0] d);
    req_i = 1'b1; wren_i = 1'b1; address_i = a; data_i = d;
  endtask

  task automatic set_read(input logic [A-1:0] a);
    req_i = 1'b1; wren_i = 1'b0; address_i = a; data_i = '0;
  endtask

  task automatic do_write(input logic [A-1:0] a, input logic [L-1:0] d);
    set_write(a, d); tick(); set_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; button_i = 1'b0; set_idle();
    tick(); tick();
    rst = 1'b0;
    n_total++; if (data_o !== 8'h00) $display("FAIL reset_data got=%h exp=00", data_o); else n_pass++;
    n_total++; if (rvalid_o !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", rvalid_o); else n_pass++;
    n_total++; if (LEDs_o !== 8'h00) $display("FAIL reset_leds got=%h exp=00", LEDs_o); else n_pass++;
    n_total++; if (range_err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", range_err_o); else n_pass++;
  endtask

  task automatic test_burst();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      set_write(A'(i), exp_d[i]); tick();
      n_total++; if (rvalid_o !== 1'b0) $display("FAIL burst_wr_norvalid i=%0d got=%b exp=0", i, rvalid_o); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      set_read(A'(i)); tick();
      n_total++; if (rvalid_o !== 1'b1) $display("FAIL burst_rvalid i=%0d got=%b exp=1", i, rvalid_o); else n_pass++;
      n_total++; if (data_o !== exp_d[i]) $display("FAIL burst_data i=%0d got=%h exp=%h", i, data_o, exp_d[i]); else n_pass++;
    end
    set_idle(); tick();
    n_total++; if (rvalid_o !== 1'b0) $display("FAIL burst_end_rvalid got=%b exp=0", rvalid_o); else n_pass++;
    n_total++; if (data_o !== 8'h33) $display("FAIL burst_hold_data got=%h exp=33", data_o); else n_pass++;
  endtask

  task automatic test_write_then_read();
    set_write(32'd7, 8'h5A); tick();
    set_read(32'd7); tick(); set_idle();
    n_total++; if (rvalid_o !== 1'b1) $display("FAIL wr_rd_rvalid got=%b exp=1", rvalid_o); else n_pass++;
    n_total++; if (data_o !== 8'h5A) $display("FAIL wr_rd_data got=%h exp=5a", data_o); else n_pass++;
  endtask

  task automatic test_leds();
    do_write(IO_BASE, 8'hC3);
    n_total++; if (LEDs_o !== 8'hC3) $display("FAIL led_write got=%h exp=c3", LEDs_o); else n_pass++;
    set_read(IO_BASE); tick(); set_idle();
    n_total++; if (data_o !== 8'hC3) $display("FAIL led_read got=%h exp=c3", data_o); else n_pass++;
    // Reset in the same cycle as a read: that response must be discarded
    set_read(32'd7); rst = 1'b1; tick(); rst = 1'b0; set_idle();
    n_total++; if (LEDs_o !== 8'h00) $display("FAIL led_reset got=%h exp=00", LEDs_o); else n_pass++;
    n_total++; if (rvalid_o !== 1'b0) $display("FAIL rst_midburst_rvalid got=%b exp=0", rvalid_o); else n_pass++;
    n_total++; if (data_o !== 8'h00) $display("FAIL rst_midburst_data got=%h exp=00", data_o); else n_pass++;
    set_read(32'd1); tick(); set_idle();
    n_total++; if (data_o !== 8'h22) $display("FAIL ram_kept_after_rst got=%h exp=22", data_o); else n_pass++;
  endtask

  task automatic test_button();
    // Pulse for 3 cycles, then let it settle low before reading
    button_i = 1'b1; tick(); tick(); tick();
    button_i = 1'b0; tick(); tick(); tick(); tick();
    set_read(IO_BASE + 32'd4); tick(); set_idle();
    n_total++; if (data_o !== 8'h02) $display("FAIL btn_released got=%h exp=02", data_o); else n_pass++;
    set_read(IO_BASE + 32'd4); tick(); set_idle();
    n_total++; if (data_o !== 8'h00) $display("FAIL btn_cleared got=%h exp=00", data_o); else n_pass++;
    // Held press: level and flag both set
    button_i = 1'b1; tick(); tick(); tick(); tick();
    set_read(IO_BASE + 32'd4); tick(); set_idle();
    n_total++; if (data_o !== 8'h03) $display("FAIL btn_held got=%h exp=03", data_o); else n_pass++;
    set_read(IO_BASE + 32'd4); tick(); set_idle();
    n_total++; if (data_o !== 8'h01) $display("FAIL btn_held_cleared got=%h exp=01", data_o); else n_pass++;
    // Release and settle, then press so the edge lands on the clearing read
    button_i = 1'b0; tick(); tick(); tick(); tick();
    button_i = 1'b1; tick(); tick();
    set_read(IO_BASE + 32'd4); tick(); set_idle();
    n_total++; if (data_o !== 8'h01) $display("FAIL btn_edge_on_read got=%h exp=01", data_o); else n_pass++;
    set_read(IO_BASE + 32'd4); tick(); set_idle();
    n_total++; if (data_o !== 8'h03) $display("FAIL btn_set_wins got=%h exp=03", data_o); else n_pass++;
    button_i = 1'b0; tick(); tick(); tick(); tick();
    set_read(IO_BASE + 32'd4); tick(); set_idle();
  endtask

  task automatic test_range();
    set_read(32'd7); tick(); set_idle();
    set_read(A'(DEPTH)); tick(); set_idle();
    n_total++; if (rvalid_o !== 1'b1) $display("FAIL oor_rvalid got=%b exp=1", rvalid_o); else n_pass++;
    n_total++; if (data_o !== 8'h00) $display("FAIL oor_data got=%h exp=00", data_o); else n_pass++;
    n_total++; if (range_err_o !== 1'b1) $display("FAIL oor_err_set got=%b exp=1", range_err_o); else n_pass++;
    set_read(IO_BASE + 32'd8); tick(); set_idle();
    n_total++; if (data_o !== 8'h01) $display("FAIL err_reg_read got=%h exp=01", data_o); else n_pass++;
    do_write(IO_BASE + 32'd8, 8'h00);
    n_total++; if (range_err_o !== 1'b0) $display("FAIL err_clear got=%b exp=0", range_err_o); else n_pass++;
    // Dropped write: address DEPTH must not alias onto RAM byte 0
    do_write(A'(DEPTH), 8'hEE);
    n_total++; if (range_err_o !== 1'b1) $display("FAIL oor_wr_err got=%b exp=1", range_err_o); else n_pass++;
    set_read(32'd0); tick(); set_idle();
    n_total++; if (data_o !== 8'h11) $display("FAIL oor_wr_dropped got=%h exp=11", data_o); else n_pass++;
    do_write(IO_BASE + 32'd8, 8'h00);
    set_read(IO_BASE + 32'd16); tick(); set_idle();
    n_total++; if (range_err_o !== 1'b1) $display("FAIL io_top_oor got=%b exp=1", range_err_o); else n_pass++;
    do_write(IO_BASE + 32'd8, 8'h00);
    set_read(IO_BASE - 32'd1); tick(); set_idle();
    n_total++; if (range_err_o !== 1'b1) $display("FAIL io_below_oor got=%b exp=1", range_err_o); else n_pass++;
    do_write(IO_BASE + 32'd8, 8'h00);
    set_read(A'(DEPTH - 1)); tick(); set_idle();
    n_total++; if (range_err_o !== 1'b0) $display("FAIL ram_top_inrange got=%b exp=0", range_err_o); else n_pass++;
  endtask

  task automatic test_mmio_misc();
    set_read(IO_BASE + 32'hC); tick(); set_idle();
    n_total++; if (data_o !== 8'hA5) $display("FAIL id_read got=%h exp=a5", data_o); else n_pass++;
    do_write(IO_BASE + 32'h1, 8'h77);
    set_read(IO_BASE + 32'h1); tick(); set_idle();
    n_total++; if (data_o !== 8'h00) $display("FAIL unmapped_read got=%h exp=00", data_o); else n_pass++;
    n_total++; if (LEDs_o !== 8'h00) $display("FAIL unmapped_wr_leds got=%h exp=00", LEDs_o); else n_pass++;
`ifndef VECTOR_MEM_ACCESS_COUNTER_EN
    set_read(IO_BASE + 32'h5); tick(); set_idle();
    n_total++; if (data_o !== 8'h00) $display("FAIL nocnt_rd_off got=%h exp=00", data_o); else n_pass++;
`endif
  endtask

`ifdef VECTOR_MEM_ACCESS_COUNTER_EN
  task automatic test_counters();
    logic [L-1:0] exp_q[$];
    do_write(IO_BASE + 32'h5, 8'h00);
    for (int i = 0; i < 20; i++) begin
      set_write(32'h40 + A'(i), 8'h80 + 8'(i)); exp_q.push_back(8'h80 + 8'(i)); tick();
    end
    for (int i = 0; i < 20; i++) begin
      set_read(32'h40 + A'(i)); tick();
      n_total++; if (data_o !== exp_q[i]) $display("FAIL vec_data i=%0d got=%h exp=%h", i, data_o, exp_q[i]); else n_pass++;
    end
    set_read(IO_BASE + 32'h5); tick(); set_idle();
    n_total++; if (data_o !== 8'h14) $display("FAIL rd_cnt got=%h exp=14", data_o); else n_pass++;
    set_read(IO_BASE + 32'h6); tick(); set_idle();
    n_total++; if (data_o !== 8'h14) $display("FAIL wr_cnt got=%h exp=14", data_o); else n_pass++;
    set_read(IO_BASE + 32'h5); tick(); set_idle();
    n_total++; if (data_o !== 8'h16) $display("FAIL rd_cnt_after got=%h exp=16", data_o); else n_pass++;
    do_write(IO_BASE + 32'h6, 8'h00);
    set_read(IO_BASE + 32'h6); tick(); set_idle();
    n_total++; if (data_o !== 8'h00) $display("FAIL cnt_clear got=%h exp=00", data_o); else n_pass++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_burst();
    test_write_then_read();
    test_leds();
    test_button();
    test_range();
    test_mmio_misc();
`ifdef VECTOR_MEM_ACCESS_COUNTER_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vector_mem_responder.md
Name: vector_mem_responder

Overview:
- Memory-side responder for the memory stage's byte-serial access bus: one byte access per cycle (address, data, write enable) while the stage steps through scalar or vector transfers.
- Holds a byte-wide synchronous data RAM plus a small memory-mapped I/O window: LED register, button status, access error.
- Sits directly under the memory stage, replacing the flat data memory.
- Reads return registered data one cycle after the request.

Parameters:
- L, 8, data/item width in bits
- A, 32, address width in bits
- DEPTH, 1024, RAM size in bytes (power of two); valid RAM addresses 0..DEPTH-1
- IO_BASE, 32'hFFFF_FF00, base of the MMIO window
- NLED, 8, LED register width (NLED <= L)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_i  in  1  access strobe; address/data/wren sampled only when high
- address_i  in  A  byte address
- data_i  in  L  write data
- wren_i  in  1  1 = write, 0 = read (qualified by req_i)
- button_i  in  1  raw asynchronous push-button input
- data_o  out  L  read data, valid the cycle after a read request
- rvalid_o  out  1  pulses high with data_o for each completed read
- LEDs_o  out  NLED  LED register contents
- range_err_o  out  1  sticky: any access outside RAM and MMIO since the last clear

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - data_o = 0, rvalid_o = 0, LEDs_o = 0, range_err_o = 0.
  - Button synchronizer, press flag and error flag cleared.
  - RAM contents are not cleared.
- Address decode (combinational on address_i):
  - RAM when address_i < DEPTH.
  - MMIO when IO_BASE <= address_i < IO_BASE+16.
  - Otherwise out of range.
- MMIO map (offset from IO_BASE):
  - 0x0 LED register: R/W, low NLED bits; upper read bits are 0.
  - 0x4 button status: RO. Bit0 = synchronized level, bit1 = sticky press flag.
  - 0x8 error status: RO bit0 = range_err_o; any write clears it.
  - 0xC ID: RO constant 8'hA5.
  - Other offsets read 0; writes to them are ignored.
- Write (req_i=1, wren_i=1):
  - Target updated at the rising edge.
  - No response; rvalid_o stays 0.
  - A RAM write followed next cycle by a read of the same address returns the new data.
- Read (req_i=1, wren_i=0):
  - data_o and rvalid_o registered at the edge, so visible in cycle N+1 for a request in cycle N.
  - Back-to-back reads are allowed every cycle (throughput 1/cycle).
  - data_o holds its last value while rvalid_o=0.
- Out of range:
  - Write is dropped.
  - Read returns data_o = 0 with rvalid_o = 1.
  - Either sets range_err_o from the following cycle.
- Button input:
  - 2-flop synchronizer on button_i.
  - Rising edge of the synchronized level sets the press flag.
  - A read of 0x4 returns the flag, then clears it.
  - Press edge in the same cycle as the clearing read: flag ends set (set wins).
- Error flag, write to 0x8 in the same cycle as a new out-of-range event: not applicable, since the write itself is in range. An error from the previous cycle lands before the clear and is therefore cleared.
- req_i=0: no state change except synchronizer/press flag; rvalid_o=0.
- rst asserted mid-burst: the outstanding read response is discarded (rvalid_o=0 next cycle). RAM keeps any bytes already written.

Optional Feature:
- Macro: VECTOR_MEM_ACCESS_COUNTER_EN.
- When defined:
  - 16-bit read counter and 16-bit write counter, each incremented on every accepted in-range request of that type.
  - Both wrap at 0xFFFF to 0 and are reset to 0.
  - Low bytes readable at MMIO offset 0x5 (reads) and 0x6 (writes).
  - A write to either offset clears both counters.
- When undefined: offsets 0x5/0x6 read 0 and no counter flops exist.

Test Plan:
- Reset, then write 0x11,0x22,0x33 to addresses 0,1,2 on consecutive cycles, then read 0,1,2 back-to-back -> rvalid_o high for 3 consecutive cycles starting 1 cycle after the first read; data_o = 0x11,0x22,0x33.
- Write 0x5A to address 7, read address 7 the next cycle -> data_o = 0x5A, rvalid_o = 1 one cycle later.
- Write 0xC3 to IO_BASE+0 -> LEDs_o = 0xC3 next cycle; read IO_BASE+0 -> 0xC3; assert rst -> LEDs_o = 0.
- Pulse button_i high for 3 cycles; read IO_BASE+4 -> 0x03 while held, or 0x02 after release; second read -> bit1 = 0.
- Read address DEPTH -> data_o = 0, rvalid_o = 1, range_err_o = 1 from the next cycle; write to IO_BASE+8 -> range_err_o = 0 the cycle after.
- With VECTOR_MEM_ACCESS_COUNTER_EN: 20 writes then 20 reads of a vector at base 0x40 -> IO_BASE+5 reads 0x14 (20 reads counted before it; the counter read is itself counted after), IO_BASE+6 reads 0x14.
